// File: rtl/flag_cond_unit.sv
// Branch resolver: NZCV flag register plus B.cond/CBZ/CBNZ/B evaluation; FLAG_FWD_EN forwards same-cycle ALU flags.
// Latency: result valid one cycle after accept, two when a B.cond must wait for an in-flight flag write.
// Backpressure: result held stable until res_ready; br_ready only in IDLE without flush, so one branch per two cycles.
module flag_cond_unit #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flag_wr,
    input  logic              alu_negative,
    input  logic              alu_zero,
    input  logic              alu_overflow,
    input  logic              alu_carry_out,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [1:0]        br_type,
    input  logic [3:0]        br_cond,
    input  logic [DATA_W-1:0] br_reg,
    input  logic [DATA_W-1:0] br_target,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_taken,
    output logic [DATA_W-1:0] res_target,
    input  logic              flush,
    output logic [3:0]        flags_q
);

`ifdef FLAG_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t      state_q, state_d;
    logic [1:0]  type_q;
    logic [3:0]  cond_q;
    logic        reg_zero_q;
    logic [3:0]  alu_flags;
    logic [3:0]  eff_flags;
    logic        accept;
    logic        bcond_flag_wr;
    logic        in_taken;
    logic        wait_taken;
    logic        load_taken;
    logic        taken_d;

    // Flags are {N,Z,C,V}.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = !z;
            4'b0010: cond_pass = c;
            4'b0011: cond_pass = !c;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = !n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = !v;
            4'b1000: cond_pass = c && !z;
            4'b1001: cond_pass = !(c && !z);
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = !z && (n == v);
            4'b1101: cond_pass = !(!z && (n == v));
            default: cond_pass = 1'b1;
        endcase
    endfunction

    function automatic logic branch_taken(input logic [1:0] typ, input logic [3:0] cond,
                                          input logic zero, input logic [3:0] f);
        case (typ)
            2'b00:   branch_taken = cond_pass(cond, f);
            2'b01:   branch_taken = zero;
            2'b10:   branch_taken = !zero;
            default: branch_taken = 1'b1;
        endcase
    endfunction

    assign alu_flags     = {alu_negative, alu_zero, alu_carry_out, alu_overflow};
    assign br_ready      = (state_q == IDLE) && !flush;
    assign res_valid     = (state_q == HOLD);
    assign accept        = br_valid && br_ready;
    assign bcond_flag_wr = flag_wr && (br_type == 2'b00);
    assign eff_flags     = (FWD_EN && bcond_flag_wr) ? alu_flags : flags_q;
    assign in_taken      = branch_taken(br_type, br_cond, br_reg == '0, eff_flags);
    // In WAIT, flags_q already holds the write that was in flight at accept.
    assign wait_taken    = branch_taken(type_q, cond_q, reg_zero_q, flags_q);

    always_comb begin
        state_d    = state_q;
        load_taken = 1'b0;
        taken_d    = in_taken;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!FWD_EN && bcond_flag_wr) begin
                        state_d = WAIT;
                    end else begin
                        state_d    = HOLD;
                        load_taken = 1'b1;
                    end
                end
            end
            WAIT: begin
                state_d    = HOLD;
                load_taken = 1'b1;
                taken_d    = wait_taken;
            end
            HOLD: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d    = IDLE;
            load_taken = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            flags_q    <= 4'b0000;
            type_q     <= 2'b00;
            cond_q     <= 4'b0000;
            reg_zero_q <= 1'b0;
            res_taken  <= 1'b0;
            res_target <= '0;
        end else begin
            state_q <= state_d;
            if (flag_wr) begin
                flags_q <= alu_flags;
            end
            if (accept) begin
                type_q     <= br_type;
                cond_q     <= br_cond;
                reg_zero_q <= (br_reg == '0);
                res_target <= br_target;
            end
            if (load_taken) begin
                res_taken <= taken_d;
            end
        end
    end

endmodule

// File: tb/tb_flag_cond_unit.sv
// Randomized and directed bench for flag_cond_unit against a transaction-level reference model.
module tb_flag_cond_unit;
    localparam int DW = 64;

`ifdef FLAG_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flag_wr = 1'b0;
    logic          alu_negative = 1'b0, alu_zero = 1'b0, alu_overflow = 1'b0, alu_carry_out = 1'b0;
    logic          br_valid = 1'b0;
    logic          br_ready;
    logic [1:0]    br_type = 2'b00;
    logic [3:0]    br_cond = 4'b0000;
    logic [DW-1:0] br_reg = '0;
    logic [DW-1:0] br_target = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic          res_taken;
    logic [DW-1:0] res_target;
    logic          flush = 1'b0;
    logic [3:0]    flags_q;

    flag_cond_unit #(.DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .flag_wr(flag_wr),
        .alu_negative(alu_negative), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out),
        .br_valid(br_valid), .br_ready(br_ready), .br_type(br_type),
        .br_cond(br_cond), .br_reg(br_reg), .br_target(br_target),
        .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken),
        .res_target(res_target), .flush(flush), .flags_q(flags_q)
    );

    always #5 clk = ~clk;

    // Reference model: one outstanding branch, visible from cycle m_valid_at.
    int            n_vec = 0;
    int            n_bad = 0;
    int            cyc = 0;
    bit [3:0]      m_flags = 4'b0000;
    bit            m_pend = 1'b0;
    int            m_valid_at = 0;
    bit            m_taken = 1'b0;
    logic [DW-1:0] m_target = '0;

    function automatic bit model_cond(input int c, input bit [3:0] f);
        bit n, z, cf, v, base;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c / 2)
            0: base = z;
            1: base = cf;
            2: base = n;
            3: base = v;
            4: base = cf && !z;
            5: base = (n == v);
            6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c >= 14) return 1'b1;
        return (c % 2 == 1) ? !base : base;
    endfunction

    function automatic bit model_taken(input int typ, input int c, input logic [DW-1:0] r,
                                       input bit [3:0] f);
        if (typ == 1) return r == 0;
        if (typ == 2) return r != 0;
        if (typ == 3) return 1'b1;
        return model_cond(c, f);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Inputs are driven just after the falling edge; settle then compares.
    task automatic settle();
        bit exp_rv;
        #1;
        exp_rv = m_pend && (cyc >= m_valid_at);
        check("br_ready", 64'(br_ready), 64'(!m_pend && !flush));
        check("res_valid", 64'(res_valid), 64'(exp_rv));
        check("flags_q", 64'(flags_q), 64'(m_flags));
        if (exp_rv) begin
            check("res_taken", 64'(res_taken), 64'(m_taken));
            check("res_target", res_target, m_target);
        end
    endtask

    task automatic tick();
        bit exp_rv;
        bit fwd;
        bit [3:0] alu;
        exp_rv = m_pend && (cyc >= m_valid_at);
        alu = {alu_negative, alu_zero, alu_carry_out, alu_overflow};
        if (reset) begin
            m_pend  = 1'b0;
            m_flags = 4'b0000;
        end else begin
            if (flush) begin
                m_pend = 1'b0;
            end else if (m_pend) begin
                if (exp_rv && res_ready) m_pend = 1'b0;
            end else if (br_valid) begin
                fwd        = flag_wr && (br_type == 2'b00);
                m_taken    = model_taken(int'(br_type), int'(br_cond), br_reg, fwd ? alu : m_flags);
                m_target   = br_target;
                m_valid_at = cyc + ((fwd && !FWD) ? 2 : 1);
                m_pend     = 1'b1;
            end
            if (flag_wr) m_flags = alu;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic set_alu(input bit [3:0] f);
        {alu_negative, alu_zero, alu_carry_out, alu_overflow} = f;
    endtask

    task automatic do_bcond(input bit [3:0] f, input bit [3:0] c, input bit has_exp, input bit exp);
        flag_wr = 1'b1; set_alu(f); br_valid = 1'b0; res_ready = 1'b0;
        settle(); tick();
        flag_wr = 1'b0; br_valid = 1'b1; br_type = 2'b00; br_cond = c;
        br_target = {$urandom, $urandom};
        settle(); tick();
        br_valid = 1'b0; res_ready = 1'b1;
        settle();
        if (has_exp) check("pin_taken", 64'(res_taken), 64'(exp));
        tick();
        res_ready = 1'b0;
    endtask

    task automatic do_cb(input bit [1:0] typ, input logic [DW-1:0] r, input bit exp);
        flag_wr = 1'b0; br_valid = 1'b1; br_type = typ; br_reg = r;
        br_target = 64'h2000; res_ready = 1'b0;
        settle();
        check("cb_accept", 64'(br_ready), 64'(1));
        tick();
        br_valid = 1'b0; res_ready = 1'b1;
        settle();
        check("cb_valid", 64'(res_valid), 64'(1));
        check("cb_taken", 64'(res_taken), 64'(exp));
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        reset = 1'b0;
        settle();
        check("rst_flags", 64'(flags_q), 64'(0));
        check("rst_valid", 64'(res_valid), 64'(0));
        check("rst_ready", 64'(br_ready), 64'(1));
        check("rst_taken", 64'(res_taken), 64'(0));
        check("rst_target", res_target, 64'(0));
        tick();

        // Stall with Z set: EQ branch held until res_ready.
        flag_wr = 1'b1; set_alu(4'b0100);
        settle(); tick();
        flag_wr = 1'b0; br_valid = 1'b1; br_type = 2'b00; br_cond = 4'b0000; br_target = 64'h40;
        settle(); tick();
        br_valid = 1'b0; res_ready = 1'b0;
        repeat (3) begin
            settle();
            check("stall_valid", 64'(res_valid), 64'(1));
            check("stall_taken", 64'(res_taken), 64'(1));
            check("stall_target", res_target, 64'h40);
            tick();
        end
        res_ready = 1'b1;
        settle(); tick();
        res_ready = 1'b0;
        settle();
        check("stall_idle", 64'(br_ready), 64'(1));
        check("stall_drop", 64'(res_valid), 64'(0));
        tick();

        do_cb(2'b01, 64'h0, 1'b1);
        do_cb(2'b10, 64'h8000_0000_0000_0000, 1'b1);
        do_cb(2'b01, 64'h5, 1'b0);

        // Forwarding: LT accepted in the same cycle that writes N=1,V=0.
        flag_wr = 1'b1; set_alu(4'b0000);
        settle(); tick();
        set_alu(4'b1000); br_valid = 1'b1; br_type = 2'b00; br_cond = 4'b1011;
        br_target = 64'h77; res_ready = 1'b1;
        settle(); tick();
        flag_wr = 1'b0; br_valid = 1'b0;
        settle();
        if (!FWD) begin
            check("fwd_wait", 64'(res_valid), 64'(0));
            tick();
            settle();
        end
        check("fwd_valid", 64'(res_valid), 64'(1));
        check("fwd_taken", 64'(res_taken), 64'(1));
        tick();
        res_ready = 1'b0;

        // Flush while holding a result with a competing request.
        br_valid = 1'b1; br_type = 2'b11; br_target = 64'h123;
        settle(); tick();
        flush = 1'b1;
        settle();
        check("flush_hold", 64'(res_valid), 64'(1));
        check("flush_noacc", 64'(br_ready), 64'(0));
        tick();
        flush = 1'b0; br_valid = 1'b0;
        settle();
        check("flush_drop", 64'(res_valid), 64'(0));
        check("flush_ready", 64'(br_ready), 64'(1));
        check("flush_flags", 64'(flags_q), 64'(4'b1000));
        tick();

        do_bcond(4'b1001, 4'b1100, 1'b1, 1'b1);
        do_bcond(4'b0110, 4'b1000, 1'b1, 1'b0);
        do_bcond(4'b0010, 4'b0010, 1'b1, 1'b1);
        do_bcond(4'b1000, 4'b1010, 1'b1, 1'b0);
        do_bcond(4'b0000, 4'b1111, 1'b1, 1'b1);
        for (int f = 0; f < 16; f++)
            for (int c = 0; c < 16; c++)
                do_bcond(4'(f), 4'(c), 1'b0, 1'b0);

        for (int i = 0; i < 4000; i++) begin
            reset     = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            flag_wr   = ($urandom_range(0, 9) < 4);
            set_alu(4'($urandom));
            br_valid  = ($urandom_range(0, 9) < 6);
            br_type   = 2'($urandom);
            br_cond   = 4'($urandom);
            br_reg    = ($urandom_range(0, 3) == 0) ? '0 : {$urandom, $urandom};
            br_target = {$urandom, $urandom};
            res_ready = $urandom_range(0, 1) == 1;
            settle();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/flag_cond_unit.md
FLAG_COND_UNIT -- requirements
Module: flag_cond_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 64, width of br_reg and br_target / res_target.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port flag_wr, input, 1, the ALU is executing a flag-setting op this cycle.
REQ-005 SHALL have ports alu_negative / alu_zero / alu_overflow / alu_carry_out, input, 1 each, the ALU flag outputs.
REQ-006 SHALL have port br_valid, input, 1, a branch request is present.
REQ-007 SHALL have port br_ready, output, 1, the unit accepts a request this cycle.
REQ-008 SHALL have port br_type, input, 2, 00 B.cond, 01 CBZ, 10 CBNZ, 11 unconditional B.
REQ-009 SHALL have port br_cond, input, 4, the ARM condition code.
REQ-010 SHALL have port br_reg, input, DATA_W, the CBZ/CBNZ test operand.
REQ-011 SHALL have port br_target, input, DATA_W, the branch target address.
REQ-012 SHALL have ports res_valid (output, 1), res_ready (input, 1), res_taken (output, 1) and res_target (output, DATA_W), forming the resolved-branch handshake.
REQ-013 SHALL have port flush, input, 1, the pipeline flush.
REQ-014 SHALL have port flags_q, output, 4, the architectural {N,Z,C,V}.

Function
REQ-015 SHALL hold flags_q; on flag_wr=1 it loads {alu_negative, alu_zero, alu_carry_out, alu_overflow} at the next edge, in any state, including during flush.
REQ-016 SHALL implement states IDLE, WAIT and HOLD.
REQ-017 SHALL drive br_ready = (state==IDLE) && !flush.
REQ-018 SHALL, in IDLE on a request (br_valid && br_ready), latch br_type, br_cond, the br_reg zero test and br_target.
REQ-019 SHALL, on the request of REQ-018, go to HOLD, or to WAIT per REQ-027.
REQ-020 SHALL evaluate conditions on an eff_flags source: the forwarded ALU flags when forwarding applies, otherwise flags_q.
REQ-021 SHALL decode conditions as:
- EQ Z, NE !Z, HS C, LO !C, MI N, PL !N, VS V, VC !V
- HI C&!Z, LS !(C&!Z), GE N==V, LT N!=V
- GT !Z&(N==V), LE !GT, 1110/1111 always true
REQ-022 SHALL compute taken as:
- CBZ: br_reg==0
- CBNZ: br_reg!=0
- B: 1
REQ-023 SHALL, in HOLD, drive res_valid=1 with res_taken/res_target stable until res_valid && res_ready, then go to IDLE.
REQ-024 SHALL give a latency of one cycle from accept edge to res_valid, or two via WAIT; maximum throughput is one branch per two cycles.
REQ-025 SHALL, on flush=1 in any state, go to IDLE at the next edge, drop the pending result and drive res_valid=0; flush has priority over res_ready and br_valid.

Reset
REQ-026 SHALL, on reset, force state=IDLE, flags_q=0000, res_valid=0, res_taken=0 and res_target=0; reset has priority over flush and flag_wr, and a mid-HOLD result is discarded.

Configuration
REQ-027 SHALL use macro FLAG_FWD_EN.
- Defined: a B.cond accepted while flag_wr=1 evaluates on the same-cycle ALU flags and goes directly to HOLD.
- Undefined: such a B.cond goes to WAIT, evaluates on the updated flags_q the next cycle, then goes to HOLD.
- Without flag_wr, or for non-B.cond types, behaviour is identical in both builds.

Verification
REQ-028 SHALL cover reset: after reset, flags_q=0000, res_valid=0, br_ready=1.
REQ-029 SHALL cover stall-then-taken: flags_q=0100 (Z), B.cond EQ with target 0x40, res_ready=0 for 3 cycles -> res_valid held with taken=1, target 0x40 stable; IDLE after res_ready=1.
REQ-030 SHALL cover CBZ/CBNZ: CBZ br_reg=0 -> taken=1; CBNZ br_reg=0x8000_0000_0000_0000 -> taken=1; CBZ br_reg=5 -> taken=0.
REQ-031 SHALL cover forwarding: flags_q=0000, flag_wr=1 with N=1,V=0 in the same cycle as B.cond LT accept.
- FLAG_FWD_EN: res_valid next cycle, taken=1.
- Without: res_valid two cycles later, taken=1.
REQ-032 SHALL cover flush: flush asserted in HOLD with br_valid=1 -> res_valid=0 next cycle, request not accepted, flags_q unchanged unless flag_wr.
REQ-033 SHALL cover the full condition table: sweep all 16 br_cond over all 16 flag values -> res_taken matches REQ-021 in all 256 cases.
